// File: rtl/angle_ctrl_pkg.sv
// angle_ctrl_pkg: shared widths, radian scaling, ramp states and small helpers for the angle front-end.
package angle_ctrl_pkg;
   localparam int ANGLE_W = 9;
   localparam int RAD_SCALE = 1787;
   localparam int RAD_SHIFT = 10;
   typedef enum logic {ST_IDLE, ST_RAMP} ramp_state_t;
   function automatic logic [31:0] to_rad(input logic [ANGLE_W-1:0] deg);
      return (32'(deg) * 32'(RAD_SCALE)) >> RAD_SHIFT;
   endfunction
   function automatic logic [ANGLE_W-1:0] step_toward(input logic [ANGLE_W-1:0] cur,
                                                     input logic [ANGLE_W-1:0] tgt);
      return (cur < tgt) ? cur + 1'b1 : (cur > tgt) ? cur - 1'b1 : cur;
   endfunction
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-FF synchronizer, stable-sample debouncer and one-cycle press pulse for an active-low button.
module button_debounce #(
   parameter int DEB_CYCLES = 50000
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_btn,
   output logic o_press
);
   localparam int CW = $clog2(DEB_CYCLES + 1);
   logic [1:0] sync;
   logic [CW-1:0] cnt;
   logic level;
   logic settle;
   assign settle = (sync[1] != level) && (cnt == CW'(DEB_CYCLES - 1));
   always_ff @(posedge i_clock or negedge i_reset)
      if (!i_reset) begin
         sync <= 2'b11;
         cnt <= '0;
         level <= 1'b1;
         o_press <= 1'b0;
      end else begin
         sync <= {sync[0], i_btn};
         cnt <= (sync[1] == level || settle) ? '0 : cnt + 1'b1;
         level <= settle ? sync[1] : level;
         o_press <= settle && !sync[1];
      end
endmodule

// File: rtl/angle_ramp_scheduler.sv
// angle_ramp_scheduler: shared up/down/select buttons edit theta/phi targets; applied angles follow them.
// Define ANGLE_RAMP_EN for the 1 deg per RAMP_DIV-cycle ramp; otherwise applied angles copy targets after one cycle.
module angle_ramp_scheduler
   import angle_ctrl_pkg::*;
#(
   parameter int DEB_CYCLES = 50000,
   parameter int RAMP_DIV = 100000,
   parameter int THETA_INIT = 180,
   parameter int THETA_MIN = 30,
   parameter int THETA_MAX = 180,
   parameter int THETA_STEP = 5,
   parameter int PHI_INIT = 0,
   parameter int PHI_MAX = 90,
   parameter int PHI_STEP = 2
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_btn_up,
   input  logic               i_btn_down,
   input  logic               i_btn_sel,
   output logic               o_sel,
   output logic [ANGLE_W-1:0] o_disp_deg,
   output logic [ANGLE_W-1:0] o_theta_deg,
   output logic [ANGLE_W-1:0] o_phi_deg,
   output logic [31:0]        o_theta32,
   output logic [31:0]        o_phi32,
   output logic               o_busy
);
   logic up_ev, dn_ev, sel_ev, step;
   logic [ANGLE_W-1:0] theta_tgt, phi_tgt, theta_nxt, phi_nxt;
   logic [ANGLE_W-1:0] theta_up, theta_dn, phi_up, phi_dn;

   button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_up (
      .i_clock(i_clock), .i_reset(i_reset), .i_btn(i_btn_up), .o_press(up_ev));
   button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_down (
      .i_clock(i_clock), .i_reset(i_reset), .i_btn(i_btn_down), .o_press(dn_ev));
   button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_sel (
      .i_clock(i_clock), .i_reset(i_reset), .i_btn(i_btn_sel), .o_press(sel_ev));

   // limits are compared before stepping so the 9-bit target never wraps or underflows
   assign theta_up = (int'(theta_tgt) + THETA_STEP >= THETA_MAX) ? ANGLE_W'(THETA_MAX)
                                                                 : theta_tgt + ANGLE_W'(THETA_STEP);
   assign theta_dn = (int'(theta_tgt) <= THETA_MIN + THETA_STEP) ? ANGLE_W'(THETA_MIN)
                                                                 : theta_tgt - ANGLE_W'(THETA_STEP);
   assign phi_up = (int'(phi_tgt) + PHI_STEP >= PHI_MAX) ? ANGLE_W'(PHI_MAX)
                                                         : phi_tgt + ANGLE_W'(PHI_STEP);
   assign phi_dn = (int'(phi_tgt) <= PHI_STEP) ? '0 : phi_tgt - ANGLE_W'(PHI_STEP);
   assign step = !sel_ev && (up_ev ^ dn_ev);
   assign theta_nxt = (step && !o_sel) ? (up_ev ? theta_up : theta_dn) : theta_tgt;
   assign phi_nxt = (step && o_sel) ? (up_ev ? phi_up : phi_dn) : phi_tgt;
   assign o_disp_deg = o_sel ? phi_tgt : theta_tgt;

   always_ff @(posedge i_clock or negedge i_reset)
      if (!i_reset) begin
         o_sel <= 1'b0;
         theta_tgt <= ANGLE_W'(THETA_INIT);
         phi_tgt <= ANGLE_W'(PHI_INIT);
      end else begin
         o_sel <= o_sel ^ sel_ev;
         theta_tgt <= theta_nxt;
         phi_tgt <= phi_nxt;
      end

`ifdef ANGLE_RAMP_EN
   localparam int TW = $clog2(RAMP_DIV + 1);
   ramp_state_t state, state_nxt;
   logic [TW-1:0] tick, tick_nxt;
   logic differ, wrap;
   assign differ = (o_theta_deg != theta_tgt) || (o_phi_deg != phi_tgt);
   assign wrap = (state == ST_RAMP) && (tick == TW'(RAMP_DIV - 1));
   always_comb begin
      state_nxt = differ ? ST_RAMP : ST_IDLE;
      tick_nxt = (state == ST_RAMP && state_nxt == ST_RAMP && !wrap) ? tick + 1'b1 : '0;
   end
   always_ff @(posedge i_clock or negedge i_reset)
      if (!i_reset) begin
         state <= ST_IDLE;
         tick <= '0;
         o_busy <= 1'b0;
         o_theta_deg <= ANGLE_W'(THETA_INIT);
         o_phi_deg <= ANGLE_W'(PHI_INIT);
      end else begin
         state <= state_nxt;
         tick <= tick_nxt;
         o_busy <= (state_nxt == ST_RAMP);
         o_theta_deg <= wrap ? step_toward(o_theta_deg, theta_tgt) : o_theta_deg;
         o_phi_deg <= wrap ? step_toward(o_phi_deg, phi_tgt) : o_phi_deg;
      end
`else
   // without the ramp there is never a pending move; RAMP_DIV only shapes the ramp build
   assign o_busy = (RAMP_DIV < 1);
   always_ff @(posedge i_clock or negedge i_reset)
      if (!i_reset) begin
         o_theta_deg <= ANGLE_W'(THETA_INIT);
         o_phi_deg <= ANGLE_W'(PHI_INIT);
      end else begin
         o_theta_deg <= theta_tgt;
         o_phi_deg <= phi_tgt;
      end
`endif

   always_ff @(posedge i_clock or negedge i_reset)
      if (!i_reset) begin
         o_theta32 <= to_rad(ANGLE_W'(THETA_INIT));
         o_phi32 <= to_rad(ANGLE_W'(PHI_INIT));
      end else begin
         o_theta32 <= to_rad(o_theta_deg);
         o_phi32 <= to_rad(o_phi_deg);
      end
endmodule

// File: tb/tb_angle_ramp_scheduler.sv
// tb_angle_ramp_scheduler: directed scoreboard bench for angle_ramp_scheduler, ramp or copy build per ANGLE_RAMP_EN.
module tb_angle_ramp_scheduler;
   localparam int DEB = 4;
   localparam int DIV = 8;
   localparam int HOLD = DEB + 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic b_up = 1'b1, b_dn = 1'b1, b_sel = 1'b1;
   logic sel, busy;
   logic [8:0] disp, th, ph;
   logic [31:0] th32, ph32;
   int checks = 0;
   int failures = 0;
   int th_t = 180;
   int ph_t = 0;
   bit m_sel = 1'b0;
   typedef struct {
      string tag;
      logic [31:0] exp;
   } exp_t;
   exp_t sbq[$];

   always #5 clk = ~clk;

   angle_ramp_scheduler #(.DEB_CYCLES(DEB), .RAMP_DIV(DIV)) dut (
      .i_clock(clk), .i_reset(rst_n), .i_btn_up(b_up), .i_btn_down(b_dn), .i_btn_sel(b_sel),
      .o_sel(sel), .o_disp_deg(disp), .o_theta_deg(th), .o_phi_deg(ph),
      .o_theta32(th32), .o_phi32(ph32), .o_busy(busy));

   function automatic int rad(input int d);
      return (d * 1787) >> 10;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input int e);
      sbq.push_back('{tag, 32'(e)});
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      exp_t e;
      if (sbq.size() == 0) begin
         checks++;
         failures++;
         $error("FAIL sb_underflow observed=empty expected=queued");
      end else begin
         e = sbq.pop_front();
         chk(e.tag, obs, e.exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input bit u, input bit d, input bit s, input string tag);
      if (s) m_sel = !m_sel;
      else if (u != d) begin
         if (!m_sel) th_t = u ? ((th_t + 5 > 180) ? 180 : th_t + 5) : ((th_t - 5 < 30) ? 30 : th_t - 5);
         else ph_t = u ? ((ph_t + 2 > 90) ? 90 : ph_t + 2) : ((ph_t - 2 < 0) ? 0 : ph_t - 2);
      end
      push({tag, "_disp"}, m_sel ? ph_t : th_t);
      push({tag, "_sel"}, int'(m_sel));
      b_up = !u;
      b_dn = !d;
      b_sel = !s;
      cyc(HOLD);
      b_up = 1'b1;
      b_dn = 1'b1;
      b_sel = 1'b1;
      cyc(HOLD);
      pop_chk(disp);
      pop_chk(sel);
   endtask

   task automatic settle(input string tag, input int budget);
      int n = 0;
      push({tag, "_theta"}, th_t);
      push({tag, "_phi"}, ph_t);
      push({tag, "_busy"}, 0);
      while (!(busy === 1'b0 && th == th_t && ph == ph_t) && n < budget) begin
         cyc(1);
         n++;
      end
      chk({tag, "_timeout"}, 32'(n >= budget), 0);
      pop_chk(th);
      pop_chk(ph);
      pop_chk(busy);
      cyc(1);
      chk({tag, "_theta32"}, th32, rad(th_t));
      chk({tag, "_phi32"}, ph32, rad(ph_t));
   endtask

   task automatic wait_theta(input string tag, input int v, input int budget);
      int n = 0;
      while (th != v && n < budget) begin
         cyc(1);
         n++;
      end
      chk({tag, "_timeout"}, 32'(n >= budget), 0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
      th_t = 180;
      ph_t = 0;
      m_sel = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_theta"}, th, 180);
      chk({tag, "_phi"}, ph, 0);
      chk({tag, "_theta32"}, th32, 314);
      chk({tag, "_phi32"}, ph32, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_sel"}, sel, 0);
      chk({tag, "_disp"}, disp, 180);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int mn;
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
      chk_reset("rst");

      // bounce shorter than DEB never qualifies; the final hold yields one press
      push("bounce_disp", 175);
      th_t = 175;
      for (int i = 0; i < 5; i++) begin
         b_dn = 1'b0;
         cyc(2);
         b_dn = 1'b1;
         cyc(2);
      end
      b_dn = 1'b0;
      cyc(HOLD);
      b_dn = 1'b1;
      cyc(HOLD);
      pop_chk(disp);
`ifdef ANGLE_RAMP_EN
      chk("bounce_busy_rise", busy, 1);
      chk("bounce_mid_ramp", 32'(th > 175), 1);
`else
      chk("bounce_copy_busy", busy, 0);
      chk("bounce_copy_theta", th, 175);
`endif
      settle("bounce", 80);
      chk("bounce_theta32_305", th32, 305);

      press(0, 0, 1, "sel_phi");
      for (int i = 0; i < 50; i++) press(1, 0, 0, "phi_up");
      settle("phi_sat", 2000);
      press(0, 0, 1, "sel_theta");
      for (int i = 0; i < 40; i++) press(0, 1, 0, "theta_dn");
      settle("theta_sat", 3000);
      chk("theta_sat_32_52", th32, 52);

      do_reset();
      press(0, 1, 0, "redir_dn1");
      press(0, 1, 0, "redir_dn2");
`ifdef ANGLE_RAMP_EN
      wait_theta("redir_at177", 177, 200);
`endif
      press(1, 0, 0, "redir_up");
      mn = 511;
      n = 0;
      while (busy !== 1'b0 && n < 200) begin
         if (th < mn) mn = th;
         cyc(1);
         n++;
      end
      if (th < mn) mn = th;
      chk("redir_min", mn, 175);
      settle("redir", 200);

      press(1, 1, 0, "updown_same");
      press(1, 0, 1, "sel_up_same");
      settle("simul", 100);

      do_reset();
      press(0, 1, 0, "mid_dn1");
      press(0, 1, 0, "mid_dn2");
      press(0, 1, 0, "mid_dn3");
`ifdef ANGLE_RAMP_EN
      wait_theta("mid_at172", 172, 300);
      chk("mid_busy", busy, 1);
`else
      chk("mid_copy_theta", th, 165);
`endif
      #2 rst_n = 1'b0;
      #1 chk_reset("async_rst");
      cyc(1);
      rst_n = 1'b1;
      cyc(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/angle_ramp_scheduler.md
Name: angle_ramp_scheduler

Overview:
Clocked front-end that replaces direct button-edge control of the converter angles theta and phi.
- Shares one pair of up/down buttons between the theta and phi targets; a select button chooses which target they act on.
- Debounces all buttons.
- Ramps the applied angles toward their targets at a bounded rate, so the hybrid controller never sees angle steps.
- Outputs feed the hybrid controller as degrees and as radians (deg*1787>>10).

Parameters:
DEB_CYCLES, 50000, consecutive stable clock cycles a button must hold before its debounced level changes.
RAMP_DIV, 100000, clock cycles per 1-degree ramp tick.
THETA_INIT, 180, theta target/applied value after reset (deg).
THETA_MIN, 30, lower saturation limit of the theta target (deg).
THETA_MAX, 180, upper saturation limit of the theta target (deg).
THETA_STEP, 5, theta target change per press (deg).
PHI_INIT, 0, phi target/applied value after reset (deg).
PHI_MAX, 90, upper saturation limit of the phi target (deg); lower limit is 0.
PHI_STEP, 2, phi target change per press (deg).

Ports:
i_clock  input  1  system clock
i_reset  input  1  reset, asynchronous, active-low
i_btn_up  input  1  raw button, active-low, asynchronous to the clock
i_btn_down  input  1  raw button, active-low
i_btn_sel  input  1  raw button, active-low
o_sel  output  1  0 = buttons edit theta, 1 = buttons edit phi
o_disp_deg  output  9  target of the selected angle, for the display path
o_theta_deg  output  9  applied theta (deg)
o_phi_deg  output  9  applied phi (deg)
o_theta32  output  32  applied theta in rad-scaled units, (o_theta_deg*1787)>>10
o_phi32  output  32  applied phi in rad-scaled units, (o_phi_deg*1787)>>10
o_busy  output  1  high while either applied angle differs from its target

Behaviour:
- Reset values: targets and applied angles = THETA_INIT / PHI_INIT; o_sel = 0; o_busy = 0; o_theta32 = 314 and o_phi32 = 0 with default parameters; debouncer and tick counters = 0.
- Input conditioning: each button passes a 2-FF synchronizer, then a debouncer. The debounced level changes only after DEB_CYCLES consecutive equal samples. A press event is a one-cycle pulse on the debounced 1->0 edge. Releases generate no event.
- Event priority, same cycle:
  - sel event toggles o_sel; up/down events in that cycle are dropped.
  - up and down together with no sel: both dropped.
  - up: selected target += STEP, saturating at its MAX.
  - down: selected target -= STEP, saturating at its MIN (theta) or 0 (phi).
  - Saturation clamps the value; it never wraps. Width is 9-bit unsigned; the subtraction is guarded so it never underflows.
- Ramp FSM, two states:
  - IDLE: both applied values equal their targets; tick counter held at 0. Go to RAMP the cycle after any target differs from its applied value.
  - RAMP: tick counter counts 0..RAMP_DIV-1. On wrap, each applied angle that differs from its target moves 1 deg toward it; both move on the same tick. Return to IDLE when both are equal.
- o_busy = (state == RAMP), registered.
- A target change mid-ramp redirects immediately: the next tick moves toward the new target, and the tick counter is not restarted.
- o_theta32 / o_phi32 are registered, one cycle after the applied value changes. The multiply is 32-bit unsigned.
- o_disp_deg is combinational from o_sel and the targets.
- Reset asserted mid-ramp returns everything to reset values asynchronously.

Optional Feature:
ANGLE_RAMP_EN
- Defined: ramp FSM as above.
- Undefined: applied angles copy targets one cycle after the target changes; no tick counter; o_busy tied to 0.

Decomposition:
- Shared package angle_ctrl_pkg holds:
  - ANGLE_W = 9
  - RAD_SCALE = 1787
  - RAD_SHIFT = 10
  - ramp state enum {ST_IDLE, ST_RAMP}
- One sub-module, button_debounce: synchronizer + stable counter + falling-edge pulse. Parameter DEB_CYCLES; instantiated three times.

Test Plan:
Bench parameters: DEB_CYCLES=4, RAMP_DIV=8.
1. Reset release, no presses -> o_theta_deg=180, o_phi_deg=0, o_theta32=314, o_busy=0, o_sel=0.
2. Bounce: i_btn_down toggling every 2 clocks for 20 clocks, then held low -> exactly one event; theta target 175; o_busy rises; after 5 ticks (40 clocks) o_theta_deg=175, o_theta32=305, o_busy=0.
3. Saturation:
   - sel press, then 50 up presses -> phi target 90, never wraps.
   - sel press, then 40 down presses on theta -> target 30; final o_theta32=52.
4. Redirect: theta 180, down x2 (target 170); after 3 ticks (applied 177), up x1 (target 175) -> applied ramps 177->176->175 and stops; o_busy falls.
5. Simultaneous events: up and down pulse same cycle -> no change. Sel plus up same cycle -> o_sel toggles, target unchanged.
6. Reset asserted mid-ramp (applied theta 172) -> all outputs return to reset values immediately, without waiting for a clock edge.
